// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Single source of the opcode encoding, FSM states and result width.
package alu_arb_pkg;

    localparam int unsigned OPND_W = 3;
    localparam int unsigned RES_W  = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [RES_W-1:0] zeroExtend(input logic [OPND_W-1:0] v);
        return {{(RES_W - OPND_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 3-bit ALU producing a 6-bit result.
// SUB wraps modulo 64; MUL of two 3-bit operands always fits in 6 bits.
module alu_core
    import alu_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [1:0]        op,
    output logic [RES_W-1:0]  y
);

    logic [RES_W-1:0] aExt;
    logic [RES_W-1:0] bExt;

    assign aExt = zeroExtend(a);
    assign bExt = zeroExtend(b);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_ADD:  y = aExt + bExt;
            OP_SUB:  y = aExt - bExt;
            OP_MUL:  y = aExt * bExt;
            OP_XOR:  y = aExt ^ bExt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter feeding one shared ALU: IDLE accepts, EXEC computes, RESP holds the result.
// Optional per-requester saturating grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [OPND_W-1:0]    req0_a,
    input  logic [OPND_W-1:0]    req0_b,
    input  logic [OPND_W-1:0]    req1_a,
    input  logic [OPND_W-1:0]    req1_b,
    input  logic [1:0]           req0_op,
    input  logic [1:0]           req1_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_result,
    output logic                 rsp_src,
    output logic                 busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
`endif
);

    state_e              state_q;
    logic                lastGrant_q;
    logic                src_q;
    logic [OPND_W-1:0]   opA_q;
    logic [OPND_W-1:0]   opB_q;
    op_e                 op_q;
    logic                rspValid_q;
    logic [RES_W-1:0]    rspResult_q;
    logic                rspSrc_q;

    logic                grant0;
    logic                grant1;
    logic                accept;
    logic                src_d;
    logic [OPND_W-1:0]   opA_d;
    logic [OPND_W-1:0]   opB_d;
    op_e                 op_d;
    logic [RES_W-1:0]    aluY;

    // lastGrant_q == 1 means requester 1 won the previous accept, so requester 0 wins a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = lastGrant_q;
                grant1 = ~lastGrant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept = grant0 | grant1;
    assign src_d  = grant1;

    always_comb begin
        opA_d = req0_a;
        opB_d = req0_b;
        op_d  = op_e'(req0_op);
        if (grant1) begin
            opA_d = req1_a;
            opB_d = req1_b;
            op_d  = op_e'(req1_op);
        end
    end

    alu_core u_alu_core (
        .a  (opA_q),
        .b  (opB_q),
        .op (op_q),
        .y  (aluY)
    );

    // Single FSM block; every response output is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= 1'b1;
            src_q       <= 1'b0;
            opA_q       <= '0;
            opB_q       <= '0;
            op_q        <= OP_ADD;
            rspValid_q  <= 1'b0;
            rspResult_q <= '0;
            rspSrc_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_EXEC;
                        lastGrant_q <= src_d;
                        src_q       <= src_d;
                        opA_q       <= opA_d;
                        opB_q       <= opB_d;
                        op_q        <= op_d;
                    end
                end
                ST_EXEC: begin
                    state_q     <= ST_RESP;
                    rspValid_q  <= 1'b1;
                    rspResult_q <= aluY;
                    rspSrc_q    <= src_q;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q    <= ST_IDLE;
                        rspValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rspValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = rspResult_q;
    assign rsp_src    = rspSrc_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grantCnt0_q;
    logic [CNT_W-1:0] grantCnt1_q;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantCnt0_q <= '0;
            grantCnt1_q <= '0;
        end else if (accept) begin
            if (!src_d && grantCnt0_q != {CNT_W{1'b1}}) begin
                grantCnt0_q <= grantCnt0_q + CNT_W'(1);
            end
            if (src_d && grantCnt1_q != {CNT_W{1'b1}}) begin
                grantCnt1_q <= grantCnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = grantCnt0_q;
    assign grant_cnt1 = grantCnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed vectors push expected responses into a queue,
// and a monitor pops and compares whenever a response handshake occurs.
module tb_alu_req_arbiter;

    localparam int unsigned TB_CNT_W = 2;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_SUB = 2'b01;
    localparam logic [1:0] C_MUL = 2'b10;
    localparam logic [1:0] C_XOR = 2'b11;

    typedef struct packed {
        logic       src;
        logic [5:0] result;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [2:0] req0_a;
    logic [2:0] req0_b;
    logic [2:0] req1_a;
    logic [2:0] req1_b;
    logic [1:0] req0_op;
    logic [1:0] req1_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_result;
    logic       rsp_src;
    logic       busy;
`ifdef ALU_ARB_STATS_EN
    logic [TB_CNT_W-1:0] grant_cnt0;
    logic [TB_CNT_W-1:0] grant_cnt1;
`endif

    exp_t expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;

    alu_req_arbiter #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_src    (rsp_src),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            passCnt++;
        end
    endtask

    task automatic applyStimulus(input int src, input logic v, input logic [2:0] a,
                                 input logic [2:0] b, input logic [1:0] op);
        if (src == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic pushExp(input logic src, input logic [5:0] result);
        exp_t e;
        e.src    = src;
        e.result = result;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: samples on the inactive edge, pops on every response handshake
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
                checkOutput("rsp_src", 32'(rsp_src), 32'(e.src));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        applyStimulus(0, 1'b0, 3'd0, 3'd0, C_ADD);
        applyStimulus(1, 1'b0, 3'd0, 3'd0, C_ADD);

        // Reset values, including ready gated low while reset is held
        #3;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("reset_rsp_src", 32'(rsp_src), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checkOutput("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #18;
        rst = 1'b0;

        // Single request: 3+4 from requester 0, then operand change after accept
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 3'd3, 3'd4, C_ADD);
        pushExp(1'b0, 6'd7);
        #1;
        checkOutput("single_grant", 32'({req1_ready, req0_ready}), 32'b01);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 3'd0, 3'd4, C_ADD);
        #1;
        checkOutput("single_exec_busy", 32'(busy), 32'd1);
        checkOutput("single_exec_novalid", 32'(rsp_valid), 32'd0);
        checkOutput("single_exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk); #2;
        checkOutput("single_latency", 32'(rsp_valid), 32'd1);
        @(posedge clk); #2;
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        checkOutput("single_idle_valid", 32'(rsp_valid), 32'd0);

        // Restore the tie-break pointer, then contention alternates 0,1,0,1
        rst = 1'b1; #2; rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 3'd1, 3'd2, C_SUB);
        applyStimulus(1, 1'b1, 3'd7, 3'd7, C_MUL);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                pushExp(1'b0, 6'h3F);
                checkOutput("contend_grant", 32'({req1_ready, req0_ready}), 32'b01);
            end else begin
                pushExp(1'b1, 6'd49);
                checkOutput("contend_grant", 32'({req1_ready, req0_ready}), 32'b10);
            end
            @(posedge clk); #1;
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            checkOutput("contend_exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
            @(posedge clk);
            @(posedge clk); #2;
        end
        checkOutput("contend_done_busy", 32'(busy), 32'd0);

        // Backpressure: hold the response 5 cycles while requester 0 waits
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        applyStimulus(1, 1'b1, 3'd5, 3'd3, C_XOR);
        pushExp(1'b1, 6'd6);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 3'd0, 3'd0, C_ADD);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 3'd1, 3'd1, C_ADD);
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_result", 32'(rsp_result), 32'd6);
            checkOutput("bp_src", 32'(rsp_src), 32'd1);
            checkOutput("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk); #2;
        checkOutput("bp_after_busy", 32'(busy), 32'd0);
        checkOutput("bp_after_grant", 32'({req1_ready, req0_ready}), 32'b01);
        applyStimulus(0, 1'b0, 3'd0, 3'd0, C_ADD);
        @(posedge clk); #2;
        checkOutput("drop_no_accept", 32'(busy), 32'd0);

        // Reset during EXEC discards 2*3; first tie afterwards goes to requester 0
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 3'd2, 3'd3, C_MUL);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 3'd0, 3'd0, C_ADD);
        #1;
        checkOutput("mid_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_result", 32'(rsp_result), 32'd0);
        checkOutput("mid_rst_src", 32'(rsp_src), 32'd0);
        applyStimulus(0, 1'b1, 3'd6, 3'd2, C_SUB);
        applyStimulus(1, 1'b1, 3'd7, 3'd7, C_MUL);
        #1;
        checkOutput("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        pushExp(1'b0, 6'd4);
        #1;
        checkOutput("post_rst_tie", 32'({req1_ready, req0_ready}), 32'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checkOutput("post_rst_novalid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("post_rst_idle", 32'(busy), 32'd0);

`ifdef ALU_ARB_STATS_EN
        // Five accepts by requester 1 saturate its 2-bit counter at 3
        rst = 1'b1; #2; rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 3'd1, 3'd1, C_ADD);
        for (int k = 0; k < 5; k++) begin
            pushExp(1'b1, 6'd2);
            @(posedge clk); #1;
            if (k == 4) req1_valid = 1'b0;
            @(posedge clk);
            @(posedge clk); #2;
        end
        checkOutput("stats_cnt1", 32'(grant_cnt1), 32'd3);
        checkOutput("stats_cnt0", 32'(grant_cnt0), 32'd0);
`endif

        repeat (4) @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
